seg_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for the 4-digit common-anode 7-segment display. It consumes the formatted digit codes and one-hot decimal-point position produced by the display formatting stage. It sequences the four digits with a configurable on-time and an inter-digit blanking gap. Inputs are latched only at frame boundaries, so the display never tears, and an optional blink mode is used for error indication.

---
 rtl/display_pkg.sv | 27 ++
 rtl/seg_scan_ctrl_if.sv | 23 ++
 rtl/seg_decoder.sv | 29 ++
 rtl/seg_scan_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 136 +++++++++++++
 5 files changed

// File: rtl/display_pkg.sv
// Shared display definitions: digit codes agreed with the formatter,
// active-high segment patterns {g,f,e,d,c,b,a} and the scan state type.
package display_pkg;

    localparam logic [3:0] DIG_BLANK = 4'd10;
    localparam logic [3:0] DIG_MINUS = 4'd11;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_MINUS = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_BLANK = 2'd2
    } scan_state_t;

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Digit data in from the formatting stage, anode/segment drive out to the display.
interface seg_scan_ctrl_if;

    logic        enable;
    logic [15:0] num_in;
    logic [3:0]  dp_in;
    logic        blink_en;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp_out;
    logic        frame_start;

    modport master (
        output enable, num_in, dp_in, blink_en,
        input  an, seg, dp_out, frame_start
    );

    modport slave (
        input  enable, num_in, dp_in, blink_en,
        output an, seg, dp_out, frame_start
    );

endinterface

// File: rtl/seg_decoder.sv
// Combinational digit code to active-high 7-segment pattern; codes 10 and 12-15 are blank.
module seg_decoder
    import display_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] pattern
);

    // Pattern lookup, anything not a digit or minus shows nothing
    always_comb begin
        pattern = SEG_BLANK;
        case (code)
            4'd0:      pattern = SEG_0;
            4'd1:      pattern = SEG_1;
            4'd2:      pattern = SEG_2;
            4'd3:      pattern = SEG_3;
            4'd4:      pattern = SEG_4;
            4'd5:      pattern = SEG_5;
            4'd6:      pattern = SEG_6;
            4'd7:      pattern = SEG_7;
            4'd8:      pattern = SEG_8;
            4'd9:      pattern = SEG_9;
            DIG_MINUS: pattern = SEG_MINUS;
            DIG_BLANK: pattern = SEG_BLANK;
            default:   pattern = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed scan controller. Digit data is captured into shadow
// registers only at frame boundaries; outputs are registered from the next-state
// values so an, seg and dp_out always change together.
module seg_scan_ctrl
    import display_pkg::*;
#(
    parameter int DIGIT_CYCLES   = 50000,
    parameter int BLANK_CYCLES   = 500,
    parameter int BLINK_FRAMES   = 125,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    seg_scan_ctrl_if.slave  bus
);

    localparam int CNT_MAX = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int FRM_W   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [CNT_W-1:0] DIG_LAST = CNT_W'(DIGIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);

    localparam logic [3:0] AN_INV  = AN_ACTIVE_LOW  ? 4'hF  : 4'h0;
    localparam logic [6:0] SEG_INV = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic       DP_INV  = SEG_ACTIVE_LOW;

    scan_state_t      state, state_nx;
    logic [1:0]       digit, digit_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [FRM_W-1:0] frm_cnt, frm_cnt_nx;
    logic             blink_on, blink_on_nx;
    logic [15:0]      num_sh, num_nx;
    logic [3:0]       dp_sh, dp_nx;
    logic             blink_sh, blink_nx;
    logic             load_frame;
    logic             step_digit;

    logic [3:0]       code_nx;
    logic [6:0]       pattern_nx;
    logic [3:0]       an_act;
    logic [6:0]       seg_act;
    logic             dp_act;

    seg_decoder u_decoder (
        .code    (code_nx),
        .pattern (pattern_nx)
    );

    // Next-state logic: scan FSM, prescaler, digit index, frame reload and blink timing
    always_comb begin
        state_nx    = state;
        digit_nx    = digit;
        cnt_nx      = cnt;
        frm_cnt_nx  = frm_cnt;
        blink_on_nx = blink_on;
        num_nx      = num_sh;
        dp_nx       = dp_sh;
        blink_nx    = blink_sh;
        load_frame  = 1'b0;
        step_digit  = 1'b0;

        if (!bus.enable) begin
            state_nx = ST_IDLE;
            digit_nx = 2'd3;
            cnt_nx   = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state_nx   = ST_DRIVE;
                    digit_nx   = 2'd3;
                    cnt_nx     = '0;
                    load_frame = 1'b1;
                end
                ST_DRIVE: begin
                    if (cnt == DIG_LAST) begin
                        cnt_nx = '0;
                        if (BLANK_CYCLES == 0) begin
                            step_digit = 1'b1;
                        end else begin
                            state_nx = ST_BLANK;
                        end
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
                ST_BLANK: begin
                    if (cnt == BLK_LAST) begin
                        cnt_nx     = '0;
                        state_nx   = ST_DRIVE;
                        step_digit = 1'b1;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
                default: begin
                    state_nx = ST_IDLE;
                    cnt_nx   = '0;
                end
            endcase

            if (step_digit) begin
                if (digit == 2'd0) begin
                    digit_nx   = 2'd3;
                    load_frame = 1'b1;
                end else begin
                    digit_nx = digit - 2'd1;
                end
            end
        end

        if (load_frame) begin
            num_nx   = bus.num_in;
            dp_nx    = bus.dp_in;
            blink_nx = bus.blink_en;
        end

        if (!bus.enable || state == ST_IDLE || !blink_sh) begin
            frm_cnt_nx  = '0;
            blink_on_nx = 1'b1;
        end else if (load_frame) begin
            if (frm_cnt == FRM_LAST) begin
                frm_cnt_nx  = '0;
                blink_on_nx = ~blink_on;
            end else begin
                frm_cnt_nx = frm_cnt + 1'b1;
            end
        end
    end

    // Active-high drive values derived from the state being entered
    always_comb begin
        code_nx = num_nx[{digit_nx, 2'b00} +: 4];
        an_act  = 4'b0000;
        seg_act = SEG_BLANK;
        dp_act  = 1'b0;
        if (state_nx == ST_DRIVE) begin
            seg_act = pattern_nx;
            dp_act  = dp_nx[digit_nx];
            if (!(blink_nx && !blink_on_nx)) begin
                an_act = 4'b0001 << digit_nx;
            end
        end
    end

    // Control state, counters and shadow registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            digit    <= 2'd3;
            cnt      <= '0;
            frm_cnt  <= '0;
            blink_on <= 1'b1;
            num_sh   <= '0;
            dp_sh    <= '0;
            blink_sh <= 1'b0;
        end else begin
            state    <= state_nx;
            digit    <= digit_nx;
            cnt      <= cnt_nx;
            frm_cnt  <= frm_cnt_nx;
            blink_on <= blink_on_nx;
            num_sh   <= num_nx;
            dp_sh    <= dp_nx;
            blink_sh <= blink_nx;
        end
    end

    // Registered display outputs with polarity applied
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.an          <= AN_INV;
            bus.seg         <= SEG_INV;
            bus.dp_out      <= DP_INV;
            bus.frame_start <= 1'b0;
        end else begin
            bus.an          <= an_act ^ AN_INV;
            bus.seg         <= seg_act ^ SEG_INV;
            bus.dp_out      <= dp_act ^ DP_INV;
            bus.frame_start <= load_frame;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with 4-cycle digits, 1-cycle gaps, 2-frame blink.
module tb_seg_scan_ctrl;

    logic clk;
    logic rst_n;
    int   vectors;
    int   fails;

    seg_scan_ctrl_if bus ();

    seg_scan_ctrl #(
        .DIGIT_CYCLES   (4),
        .BLANK_CYCLES   (1),
        .BLINK_FRAMES   (2),
        .SEG_ACTIVE_LOW (1'b1),
        .AN_ACTIVE_LOW  (1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Free-running 10-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value
    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        if (obs !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Drive the formatter-side inputs
    task automatic applyStimulus(input logic en, input logic [15:0] num,
                                 input logic [3:0] dp, input logic blink);
        bus.enable   = en;
        bus.num_in   = num;
        bus.dp_in    = dp;
        bus.blink_en = blink;
    endtask

    // Expect all outputs inactive at the next falling edge
    task automatic checkIdle(input string tag);
        @(negedge clk);
        checkOutput({tag, " an"},  16'(bus.an),          16'h000F);
        checkOutput({tag, " seg"}, 16'(bus.seg),         16'h007F);
        checkOutput({tag, " dp"},  16'(bus.dp_out),      16'h0001);
        checkOutput({tag, " fs"},  16'(bus.frame_start), 16'h0000);
    endtask

    // Walk frame positions firstPos..lastPos (0..19), checking each cycle.
    // s3..s0 are active-high patterns per digit, vis=0 means anodes blinked off.
    task automatic expectFrame(input string tag, input logic [6:0] s3, input logic [6:0] s2,
                               input logic [6:0] s1, input logic [6:0] s0,
                               input logic [3:0] dp, input logic vis,
                               input int firstPos, input int lastPos);
        logic [6:0] pat [4];
        pat[3] = s3; pat[2] = s2; pat[1] = s1; pat[0] = s0;
        for (int p = firstPos; p <= lastPos; p++) begin
            logic [1:0] dig;
            logic       drive;
            logic [3:0] expAn;
            logic [6:0] expSeg;
            logic       expDp;
            string      t;
            @(negedge clk);
            dig    = 2'(3 - p / 5);
            drive  = (p % 5) < 4;
            expAn  = (drive && vis) ? ~(4'b0001 << dig) : 4'hF;
            expSeg = drive ? ~pat[dig] : 7'h7F;
            expDp  = drive ? ~dp[dig] : 1'b1;
            t = $sformatf("%s p%0d", tag, p);
            checkOutput({t, " an"},  16'(bus.an),          16'(expAn));
            checkOutput({t, " seg"}, 16'(bus.seg),         16'(expSeg));
            checkOutput({t, " dp"},  16'(bus.dp_out),      16'(expDp));
            checkOutput({t, " fs"},  16'(bus.frame_start), (p == 0) ? 16'h0001 : 16'h0000);
        end
    endtask

    initial begin
        vectors = 0;
        fails   = 0;
        rst_n   = 1'b0;
        applyStimulus(1'b0, 16'h0000, 4'b0000, 1'b0);

        checkIdle("reset");
        checkIdle("reset");
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) checkIdle("disabled");

        applyStimulus(1'b1, 16'h1234, 4'b0001, 1'b0);
        expectFrame("f1234a", 7'h06, 7'h5B, 7'h4F, 7'h66, 4'b0001, 1'b1, 0, 19);
        expectFrame("f1234b", 7'h06, 7'h5B, 7'h4F, 7'h66, 4'b0001, 1'b1, 0, 19);

        applyStimulus(1'b1, 16'hBA5A, 4'b0001, 1'b0);
        expectFrame("fBA5A", 7'h40, 7'h00, 7'h6D, 7'h00, 4'b0001, 1'b1, 0, 19);

        applyStimulus(1'b1, 16'h1234, 4'b0001, 1'b0);
        expectFrame("fmidA", 7'h06, 7'h5B, 7'h4F, 7'h66, 4'b0001, 1'b1, 0, 6);
        applyStimulus(1'b1, 16'h5678, 4'b0001, 1'b0);
        expectFrame("fmidB", 7'h06, 7'h5B, 7'h4F, 7'h66, 4'b0001, 1'b1, 7, 19);
        expectFrame("f5678", 7'h6D, 7'h7D, 7'h07, 7'h7F, 4'b0001, 1'b1, 0, 19);

        applyStimulus(1'b1, 16'h8888, 4'b0000, 1'b1);
        expectFrame("blink1", 7'h7F, 7'h7F, 7'h7F, 7'h7F, 4'b0000, 1'b1, 0, 19);
        expectFrame("blink2", 7'h7F, 7'h7F, 7'h7F, 7'h7F, 4'b0000, 1'b1, 0, 19);
        expectFrame("blink3", 7'h7F, 7'h7F, 7'h7F, 7'h7F, 4'b0000, 1'b0, 0, 19);
        expectFrame("blink4", 7'h7F, 7'h7F, 7'h7F, 7'h7F, 4'b0000, 1'b0, 0, 19);
        expectFrame("blink5", 7'h7F, 7'h7F, 7'h7F, 7'h7F, 4'b0000, 1'b1, 0, 19);

        applyStimulus(1'b1, 16'h1234, 4'b0001, 1'b0);
        expectFrame("predrop", 7'h06, 7'h5B, 7'h4F, 7'h66, 4'b0001, 1'b1, 0, 11);
        applyStimulus(1'b0, 16'h1234, 4'b0001, 1'b0);
        for (int i = 0; i < 3; i++) checkIdle("dropped");
        applyStimulus(1'b1, 16'h1234, 4'b0001, 1'b0);
        expectFrame("reenable", 7'h06, 7'h5B, 7'h4F, 7'h66, 4'b0001, 1'b1, 0, 19);
        expectFrame("prereset", 7'h06, 7'h5B, 7'h4F, 7'h66, 4'b0001, 1'b1, 0, 7);

        #2 rst_n = 1'b0;
        #1;
        checkOutput("async rst an",  16'(bus.an),          16'h000F);
        checkOutput("async rst seg", 16'(bus.seg),         16'h007F);
        checkOutput("async rst dp",  16'(bus.dp_out),      16'h0001);
        checkOutput("async rst fs",  16'(bus.frame_start), 16'h0000);
        checkIdle("held rst");
        rst_n = 1'b1;
        expectFrame("postreset", 7'h06, 7'h5B, 7'h4F, 7'h66, 4'b0001, 1'b1, 0, 19);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
